// File: rtl/fp_mul_arbiter.sv
// fp_mul_arbiter: round-robin sharing of one pipelined FP multiplier among NUM_REQ requesters,
// with a tag pipeline that returns each result to its owner.
module fp_mul_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 32,
  parameter int LATENCY = 3,
  parameter int MAX_OUT = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ*WIDTH-1:0] req_left,
  input  logic [NUM_REQ*WIDTH-1:0] req_right,
  input  logic [NUM_REQ*3-1:0]     req_rm,
  output logic [NUM_REQ-1:0]       resp_valid,
  output logic [WIDTH-1:0]         resp_out,
  output logic [4:0]               resp_flags,
  output logic                     busy,
  output logic                     mul_go,
  output logic [WIDTH-1:0]         mul_left,
  output logic [WIDTH-1:0]         mul_right,
  output logic [2:0]               mul_rm,
  input  logic [WIDTH-1:0]         mul_out,
  input  logic [4:0]               mul_flags
);
  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW = $clog2(MAX_OUT + 1);
  logic [NUM_REQ-1:0][CW-1:0]   cnt_q, cnt_d;
  logic [IW-1:0]                ptr_q, ptr_d, gidx, cand;
  logic                         found;
  logic [NUM_REQ-1:0]           elig, grant;
  logic [LATENCY-1:0]           tv_q, tv_d;
  logic [LATENCY-1:0][IW-1:0]   ti_q, ti_d;
  logic [NUM_REQ-1:0]           resp_valid_q, resp_valid_d;
  logic [WIDTH-1:0]             resp_out_q, resp_out_d;
  logic [4:0]                   resp_flags_q, resp_flags_d;
  logic                         busy_q, busy_d;

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) elig[i] = req_valid[i] && (cnt_q[i] < CW'(MAX_OUT));
  end

  // search starts just after the last winner; no grant while in reset
  always_comb begin
    found = 1'b0;
    gidx  = '0;
    cand  = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = IW'((int'(ptr_q) + k) % NUM_REQ);
      if (!found && elig[cand]) begin
        found = 1'b1;
        gidx  = cand;
      end
    end
    found = found && !reset;
    gidx  = found ? gidx : '0;
  end

  assign grant     = found ? (NUM_REQ'(1) << gidx) : '0;
  assign req_ready = grant;
  assign mul_go    = found;
  assign mul_left  = req_left[gidx*WIDTH +: WIDTH];
  assign mul_right = req_right[gidx*WIDTH +: WIDTH];
  assign mul_rm    = req_rm[gidx*3 +: 3];

  always_comb begin
    tv_d[0] = found;
    ti_d[0] = gidx;
    for (int s = 1; s < LATENCY; s++) begin
      tv_d[s] = tv_q[s-1];
      ti_d[s] = ti_q[s-1];
    end
    resp_valid_d = tv_q[LATENCY-1] ? (NUM_REQ'(1) << ti_q[LATENCY-1]) : '0;
    resp_out_d   = tv_q[LATENCY-1] ? mul_out : resp_out_q;
    resp_flags_d = tv_q[LATENCY-1] ? mul_flags : resp_flags_q;
    for (int i = 0; i < NUM_REQ; i++)
      cnt_d[i] = (grant[i] && !resp_valid_d[i]) ? cnt_q[i] + CW'(1) :
                 (!grant[i] && resp_valid_d[i]) ? cnt_q[i] - CW'(1) : cnt_q[i];
    ptr_d  = found ? gidx : ptr_q;
    busy_d = (|tv_d) || (|resp_valid_d);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tv_q         <= '0;
      ti_q         <= '0;
      cnt_q        <= '0;
      ptr_q        <= IW'(NUM_REQ - 1);
      resp_valid_q <= '0;
      resp_out_q   <= '0;
      resp_flags_q <= '0;
      busy_q       <= 1'b0;
    end else begin
      tv_q         <= tv_d;
      ti_q         <= ti_d;
      cnt_q        <= cnt_d;
      ptr_q        <= ptr_d;
      resp_valid_q <= resp_valid_d;
      resp_out_q   <= resp_out_d;
      resp_flags_q <= resp_flags_d;
      busy_q       <= busy_d;
    end
  end

  assign resp_valid = resp_valid_q;
  assign resp_out   = resp_out_q;
  assign resp_flags = resp_flags_q;
  assign busy       = busy_q;
endmodule

// File: tb/tb_fp_mul_arbiter.sv
// tb_fp_mul_arbiter: scoreboard bench for fp_mul_arbiter with a behavioural multiplier
// whose result appears LATENCY edges after issue.
module tb_fp_mul_arbiter;
  localparam int NR = 4, W = 32, LAT = 3, MO = 2;

  logic clk = 1'b0, reset = 1'b1;
  logic [NR-1:0] req_valid = '0, req_ready, resp_valid;
  logic [NR*W-1:0] req_left = '0, req_right = '0;
  logic [NR*3-1:0] req_rm = '0;
  logic [W-1:0] resp_out, mul_left, mul_right, mul_out;
  logic [4:0] resp_flags, mul_flags;
  logic busy, mul_go;
  logic [2:0] mul_rm;
  logic [LAT-1:0][W+4:0] mpipe;

  int errors = 0, checks = 0, cyc = 0;
  typedef struct {int idx; logic [W-1:0] res; logic [4:0] fl; int due;} exp_t;
  exp_t sbq[$];
  int ocnt[NR];

  fp_mul_arbiter #(.NUM_REQ(NR), .WIDTH(W), .LATENCY(LAT), .MAX_OUT(MO)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_left(req_left), .req_right(req_right), .req_rm(req_rm),
    .resp_valid(resp_valid), .resp_out(resp_out), .resp_flags(resp_flags), .busy(busy),
    .mul_go(mul_go), .mul_left(mul_left), .mul_right(mul_right), .mul_rm(mul_rm),
    .mul_out(mul_out), .mul_flags(mul_flags)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [W+4:0] mulf(input logic [W-1:0] l, input logic [W-1:0] r, input logic [2:0] rm);
    if (l == 32'h40000000 && r == 32'h40400000 && rm == 3'd0) return {32'h40C00000, 5'h00};
    if (l == 32'h7F000000 && r == 32'h7F000000 && rm == 3'd0) return {32'h7F800000, 5'h05};
    return {(l ^ {r[15:0], r[31:16]}) + {29'd0, rm}, l[4:0] ^ r[9:5] ^ {2'b00, rm}};
  endfunction

  always @(posedge clk) begin
    mpipe[0] <= mulf(mul_left, mul_right, mul_rm);
    for (int s = 1; s < LAT; s++) mpipe[s] <= mpipe[s-1];
  end
  assign {mul_out, mul_flags} = mpipe[LAT-1];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req_valid = '0;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic monitor();
    exp_t e;
    int g;
    forever begin
      @(negedge clk);
      if (reset) begin
        checks++;
        if (req_ready !== '0 || mul_go !== 1'b0) begin
          errors++;
          $display("FAIL reset_gate: ready=%b go=%b, required 0", req_ready, mul_go);
        end
        sbq.delete();
        foreach (ocnt[i]) ocnt[i] = 0;
        continue;
      end
      checks++;
      if (busy !== (sbq.size() != 0)) begin
        errors++;
        $display("FAIL busy: got %b, required %b (cycle %0d)", busy, sbq.size() != 0, cyc);
      end
      checks++;
      if ((req_ready & ~req_valid) != '0 || !$onehot0(req_ready) || mul_go !== (req_ready != '0)) begin
        errors++;
        $display("FAIL grant_legal: ready=%b valid=%b go=%b", req_ready, req_valid, mul_go);
      end
      if (resp_valid !== '0) begin
        checks++;
        if (sbq.size() == 0) begin
          errors++;
          $display("FAIL resp_unexpected: resp_valid=%b, required 0 (cycle %0d)", resp_valid, cyc);
        end else begin
          e = sbq.pop_front();
          if (resp_valid !== (NR'(1) << e.idx) || resp_out !== e.res || resp_flags !== e.fl || cyc != e.due) begin
            errors++;
            $display("FAIL resp_sb: got v=%b out=%h fl=%h cyc=%0d, required v=%b out=%h fl=%h cyc=%0d",
                     resp_valid, resp_out, resp_flags, cyc, NR'(1) << e.idx, e.res, e.fl, e.due);
          end
          ocnt[e.idx]--;
        end
      end
      if (req_ready != '0) begin
        g = 0;
        for (int i = 0; i < NR; i++) if (req_ready[i]) g = i;
        checks++;
        if (ocnt[g] >= MO) begin
          errors++;
          $display("FAIL cnt_limit: requester %0d granted with %0d outstanding, limit %0d", g, ocnt[g], MO);
        end
        ocnt[g]++;
        e.idx = g;
        {e.res, e.fl} = mulf(req_left[g*W +: W], req_right[g*W +: W], req_rm[g*3 +: 3]);
        e.due = cyc + LAT + 1;
        sbq.push_back(e);
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    req_valid = '1;
    repeat (3) begin
      @(negedge clk);
      checks++;
      if (resp_valid !== '0 || resp_out !== '0 || resp_flags !== '0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL reset_state: v=%b out=%h fl=%h busy=%b, required all 0", resp_valid, resp_out, resp_flags, busy);
      end
      checks++;
      if (req_ready !== '0 || mul_go !== 1'b0) begin
        errors++;
        $display("FAIL reset_ready: ready=%b go=%b, required 0", req_ready, mul_go);
      end
    end
    step();
    reset = 1'b0;
    req_valid = '0;
  endtask

  task automatic single_op(input int r, input logic [W-1:0] l, input logic [W-1:0] rr,
                           input logic [W-1:0] xo, input logic [4:0] xf, input string nm);
    int got;
    req_left[r*W +: W] = l;
    req_right[r*W +: W] = rr;
    req_rm[r*3 +: 3] = 3'd0;
    req_valid = NR'(1) << r;
    @(negedge clk);
    checks++;
    if (req_ready !== (NR'(1) << r)) begin
      errors++;
      $display("FAIL %s_ready: got %b, required %b", nm, req_ready, NR'(1) << r);
    end
    step();
    req_valid = '0;
    got = 0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (resp_valid !== '0) begin
        got = k;
        break;
      end
    end
    checks++;
    if (got != LAT + 1 || resp_valid !== (NR'(1) << r) || resp_out !== xo || resp_flags !== xf) begin
      errors++;
      $display("FAIL %s_resp: got lat=%0d v=%b out=%h fl=%h, required lat=%0d v=%b out=%h fl=%h",
               nm, got, resp_valid, resp_out, resp_flags, LAT + 1, NR'(1) << r, xo, xf);
    end
    step();
  endtask

  task automatic test_single();
    single_op(1, 32'h40000000, 32'h40400000, 32'h40C00000, 5'h00, "single");
  endtask

  task automatic test_overflow();
    single_op(3, 32'h7F000000, 32'h7F000000, 32'h7F800000, 5'h05, "overflow");
  endtask

  task automatic test_all_four();
    do_reset();
    for (int i = 0; i < NR; i++) begin
      req_left[i*W +: W] = $urandom;
      req_right[i*W +: W] = $urandom;
      req_rm[i*3 +: 3] = 3'($urandom_range(0, 4));
    end
    req_valid = '1;
    for (int k = 0; k < NR; k++) begin
      @(negedge clk);
      checks++;
      if (req_ready !== (NR'(1) << k)) begin
        errors++;
        $display("FAIL all4_grant%0d: got %b, required %b", k, req_ready, NR'(1) << k);
      end
      step();
      req_valid[k] = 1'b0;
    end
    for (int j = 0; j < NR; j++) begin
      @(negedge clk);
      checks++;
      if (resp_valid !== (NR'(1) << j)) begin
        errors++;
        $display("FAIL all4_resp%0d: got %b, required %b", j, resp_valid, NR'(1) << j);
      end
    end
    step();
  endtask

  task automatic test_stall();
    logic hs;
    do_reset();
    req_left[2*W +: W] = $urandom;
    req_right[2*W +: W] = $urandom;
    req_valid = 4'b0100;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      hs = req_ready[2];
      checks++;
      if (hs !== ((k % 4) < 2)) begin
        errors++;
        $display("FAIL stall_c%0d: ready[2]=%b, required %b", k, hs, (k % 4) < 2);
      end
      step();
      if (hs) begin
        req_left[2*W +: W] = $urandom;
        req_rm[2*3 +: 3] = 3'($urandom_range(0, 4));
      end
    end
    req_valid = '0;
    repeat (6) step();
  endtask

  task automatic test_same_edge();
    logic vb[6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    logic rb[6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    do_reset();
    req_left[0 +: W] = 32'h3F800000;
    req_right[0 +: W] = 32'hC0000000;
    for (int k = 0; k < 6; k++) begin
      req_valid = {3'b000, vb[k]};
      @(negedge clk);
      checks++;
      if (req_ready !== {3'b000, rb[k]}) begin
        errors++;
        $display("FAIL same_edge_c%0d: got %b, required %b", k, req_ready, {3'b000, rb[k]});
      end
      step();
    end
    req_valid = '0;
    repeat (6) step();
    do_reset();
    req_left[3*W +: W] = 32'h12345678;
    req_valid = 4'b1001;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      checks++;
      if (req_ready !== ((k % 2 == 0) ? 4'b0001 : 4'b1000)) begin
        errors++;
        $display("FAIL rotate_c%0d: got %b, required %b", k, req_ready, (k % 2 == 0) ? 4'b0001 : 4'b1000);
      end
      step();
    end
    req_valid = '0;
    repeat (6) step();
  endtask

  task automatic test_reset_mid();
    logic [NR-1:0] vs[4] = '{4'b1001, 4'b1000, 4'b0010, 4'b0010};
    logic [NR-1:0] rs[4] = '{4'b0001, 4'b1000, 4'b0010, 4'b0010};
    do_reset();
    req_valid = 4'b0110;
    @(negedge clk);
    checks++;
    if (req_ready !== 4'b0010) begin
      errors++;
      $display("FAIL mid_grant0: got %b, required 0010", req_ready);
    end
    step();
    req_valid = 4'b0100;
    @(negedge clk);
    checks++;
    if (req_ready !== 4'b0100) begin
      errors++;
      $display("FAIL mid_grant1: got %b, required 0100", req_ready);
    end
    step();
    req_valid = '0;
    reset = 1'b1;
    step();
    reset = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      checks++;
      if (resp_valid !== '0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL mid_quiet_c%0d: v=%b busy=%b, required 0 0", k, resp_valid, busy);
      end
      step();
    end
    for (int k = 0; k < 4; k++) begin
      req_valid = vs[k];
      @(negedge clk);
      checks++;
      if (req_ready !== rs[k]) begin
        errors++;
        $display("FAIL mid_after_c%0d: got %b, required %b", k, req_ready, rs[k]);
      end
      step();
    end
    req_valid = '0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    fork
      monitor();
    join_none
    test_reset();
    test_single();
    test_all_four();
    test_stall();
    test_overflow();
    test_same_edge();
    test_reset_mid();
    for (int k = 0; k < 50 && (sbq.size() != 0 || busy); k++) step();
    checks++;
    if (sbq.size() != 0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL drain: %0d pending busy=%b, required 0 pending busy=0", sbq.size(), busy);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/fp_mul_arbiter.md
# fp_mul_arbiter

Round-robin arbiter that shares one pipelined floating-point multiplier among NUM_REQ requesters. Each requester issues operations through a valid/ready handshake. The arbiter issues at most one operation per cycle, tracks each operation's owner in a tag pipeline matched to the multiplier's data latency, and returns every result to its owner with a one-hot response strobe. The block sits between the float datapath clients and the standard-format multiplier wrapper, replacing the clients' direct use of its go/done pins.

## Interface
- NUM_REQ, 4: number of requesters, 2..8.
- WIDTH, 32: operand/result width (expWidth + sigWidth).
- LATENCY, 3: clock edges from a mul_go edge until mul_out/mul_flags hold that operation's result.
- MAX_OUT, 2: maximum in-flight operations per requester, 1..LATENCY+1.
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  reset, synchronous, active-high.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_ready  out  NUM_REQ  per-requester grant; the handshake completes when valid and ready are both high.
- req_left  in  NUM_REQ*WIDTH  left operands; requester i uses slice [i*WIDTH +: WIDTH].
- req_right  in  NUM_REQ*WIDTH  right operands, sliced the same way.
- req_rm  in  NUM_REQ*3  rounding modes; requester i uses slice [i*3 +: 3].
- resp_valid  out  NUM_REQ  one-hot result strobe, high for one cycle.
- resp_out  out  WIDTH  result data, valid while any resp_valid bit is high.
- resp_flags  out  5  exception flags accompanying resp_out.
- busy  out  1  high while any operation is in flight or resp_valid is high.
- mul_go, mul_left, mul_right, mul_rm  out  1/WIDTH/WIDTH/3  multiplier issue port.
- mul_out, mul_flags  in  WIDTH/5  multiplier result port.

## Operation
- Eligibility: requester i is eligible when req_valid[i] is high and outstanding count cnt[i] < MAX_OUT.
- Grant selection:
  - Round-robin. Priority starts at ptr+1 modulo NUM_REQ; ptr is the last granted index.
  - ptr resets to NUM_REQ-1, so requester 0 wins first.
  - At most one grant per cycle.
- Grant outputs:
  - req_ready is combinational: one-hot grant, or zero.
  - While reset is high, req_ready is zero.
  - req_ready is never high for a requester whose req_valid is low.
- Issue:
  - mul_go equals the OR of the grant bits.
  - mul_left, mul_right and mul_rm are combinationally muxed from the granted requester.
  - With no grant, these outputs hold requester 0's slices. Their value is irrelevant while mul_go is low.
- Requester obligation: hold valid, operands and rounding mode stable until ready.
- Tag pipeline:
  - LATENCY stages, each holding {valid, index} with index of ceil(log2(NUM_REQ)) bits.
  - Stage 0 is loaded on the grant edge.
  - When the final stage is valid at an edge, the block registers mul_out into resp_out and mul_flags into resp_flags, and sets resp_valid to onehot(index).
  - Otherwise resp_valid returns to 0 and resp_out/resp_flags hold their last value.
- Counters:
  - cnt[i] increments on grant to i and decrements on the edge that raises resp_valid[i].
  - If both happen on the same edge, cnt[i] is unchanged.
  - cnt[i] never exceeds MAX_OUT and never underflows.
- Responses have no backpressure; requesters must sink resp_valid unconditionally.
- mul_done is not used; sequencing relies on LATENCY alone.

## Timing
- Reset values: resp_valid 0, resp_out 0, resp_flags 0, busy 0, all tag stages invalid, all cnt 0, ptr NUM_REQ-1. mul_go and req_ready are 0 while reset is high.
- Latency: a handshake at edge e gives resp_valid high in the cycle after edge e+LATENCY, i.e. LATENCY+1 cycles, fixed.
- Throughput: one issue per cycle overall.
  - A single requester alone sustains MAX_OUT issues per LATENCY+1 cycles.
  - Requester i stalls whenever cnt[i] == MAX_OUT.
- Ordering: responses return in issue order, globally and per requester.
- Reset mid-operation: all tags are discarded and no resp_valid is produced for pre-reset issues. Any stale result from the multiplier is ignored.
- busy is registered: high in any cycle where a tag stage is valid or resp_valid is high.

## Test plan
- Single request, with requester 1 issuing 0x40000000 × 0x40400000 at rm=0 → req_ready[1] in the same cycle; 4 cycles later resp_valid=0010, resp_out=0x40C00000, resp_flags=0.
- All four requesters valid from reset → grants in order 0,1,2,3 on consecutive cycles → responses in order 0,1,2,3 on consecutive cycles, each carrying its own product.
- Requester 2 holds valid continuously (MAX_OUT=2, LATENCY=3) → two grants, then ready low until the first response; cnt[2] stays ≤ 2; thereafter the pattern is 2 grants per 4 cycles.
- Overflow case, 0x7F000000 × 0x7F000000 at rm=0 → resp_out=0x7F800000, resp_flags=5'h05.
- Requester 0 is granted on the same edge its earlier result returns → cnt[0] unchanged; with requesters 0 and 3 contending, ptr rotation still alternates 0 and 3.
- Reset asserted one cycle after two issues → no resp_valid afterward; busy=0, all cnt=0, and the next grant goes to requester 0.
